// File: rtl/byte_transmitter.sv
// Serializer: shifts a WIDTH-bit word onto `out`, one bit per enabled clock, then holds `done`.
// Define BYTE_TX_MSB_FIRST_EN for MSB-first order (LSB-first by default).
module byte_transmitter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] in,
    output logic             out,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic               out_q,   out_d;
    logic               done_q,  done_d;

    // State, datapath and output flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            out_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-output logic; counter holds the number of bits already presented
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = done_q;

        case (state_q)
            IDLE: begin
                out_d  = 1'b0;
                done_d = 1'b0;
                if (enable) begin
`ifdef BYTE_TX_MSB_FIRST_EN
                    out_d   = in[WIDTH-1];
                    shreg_d = in << 1;
`else
                    out_d   = in[0];
                    shreg_d = in >> 1;
`endif
                    cnt_d   = CNT_W'(1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (enable) begin
                    if (cnt_q == CNT_W'(WIDTH)) begin
                        out_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end else begin
`ifdef BYTE_TX_MSB_FIRST_EN
                        out_d   = shreg_q[WIDTH-1];
                        shreg_d = shreg_q << 1;
`else
                        out_d   = shreg_q[0];
                        shreg_d = shreg_q >> 1;
`endif
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                out_d  = 1'b0;
                done_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
                out_d   = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    assign out  = out_q;
    assign done = done_q;

endmodule

// File: tb/tb_byte_transmitter.sv
// Self-checking bench for byte_transmitter: vector table, directed corner sequences,
// and randomized traffic against an edge-counting reference model.
module tb_byte_transmitter;

    localparam int W = 32;

    logic         clk    = 1'b0;
    logic         reset  = 1'b0;
    logic         enable = 1'b0;
    logic [W-1:0] din    = '0;
    logic         out;
    logic         done;

    int tests = 0;
    int fails = 0;

    // Reference model: the captured word and the number of enabled edges since reset
    logic [W-1:0] m_word = '0;
    int           m_k    = 0;

    typedef struct {
        logic         en;
        logic [W-1:0] din;
        logic         eo;
        logic         ed;
    } vec_t;

    vec_t tbl[36];

    always #5 clk = ~clk;

    byte_transmitter #(.WIDTH(W)) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .in     (din),
        .out    (out),
        .done   (done)
    );

    function automatic logic m_out();
        if (m_k >= 1 && m_k <= W) begin
`ifdef BYTE_TX_MSB_FIRST_EN
            return m_word[W - m_k];
`else
            return m_word[m_k - 1];
`endif
        end
        return 1'b0;
    endfunction

    task automatic check(input string name, input logic eo, input logic ed);
        tests++;
        if (out !== eo || done !== ed) begin
            fails++;
            $display("FAIL %s: out=%b done=%b, expected out=%b done=%b", name, out, done, eo, ed);
        end
    endtask

    task automatic check_model(input string name);
        check(name, m_out(), logic'(m_k > W));
    endtask

    // Drive inputs, take one clock edge, then advance the model
    task automatic tick(input logic en, input logic [W-1:0] d);
        enable = en;
        din    = d;
        @(posedge clk);
        #1;
        if (en) begin
            if (m_k == 0) m_word = d;
            if (m_k <= W) m_k++;
        end
    endtask

    // Async reset mid-cycle with random inputs, held across one edge
    task automatic async_reset();
        #2;
        enable = logic'($urandom_range(0, 1));
        din    = W'($urandom);
        reset  = 1'b1;
        #1;
        m_k = 0;
        check("async_reset", 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("reset_held", 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] word;
`ifdef BYTE_TX_MSB_FIRST_EN
        int exp_bits[33] = '{1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,
                             0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1, 0};
        word = 32'h8000_0001;
`else
        int exp_bits[33] = '{1,0,0,0,0,0,0,0, 1,1,1,1,0,1,0,1,
                             1,1,1,1,0,0,0,0, 0,0,0,0,0,0,0,0, 0};
        word = 32'h000F_AF01;
`endif
        // Full transmission; `in` is scrambled after the load to prove isolation
        for (int i = 0; i < 33; i++) begin
            tbl[i].en  = 1'b1;
            tbl[i].din = (i == 0) ? word : W'($urandom);
            tbl[i].eo  = logic'(exp_bits[i]);
            tbl[i].ed  = logic'(i == 32);
        end
        // Sticky DONE with enable toggling and all-ones input
        for (int i = 33; i < 36; i++) begin
            tbl[i].en  = logic'(i % 2);
            tbl[i].din = '1;
            tbl[i].eo  = 1'b0;
            tbl[i].ed  = 1'b1;
        end

        async_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, W'($urandom));
            check("idle_hold", 1'b0, 1'b0);
        end

        for (int i = 0; i < 36; i++) begin
            tick(tbl[i].en, tbl[i].din);
            check($sformatf("tbl[%0d]", i), tbl[i].eo, tbl[i].ed);
        end

        // Pause after edge 10, then resume to completion
        async_reset();
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, (i == 0) ? 32'h000F_AF01 : W'($urandom));
            check_model($sformatf("pre_pause[%0d]", i));
        end
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, W'($urandom));
            check_model($sformatf("pause[%0d]", i));
        end
        for (int i = 0; i < 24; i++) begin
            tick(1'b1, W'($urandom));
            check_model($sformatf("resume[%0d]", i));
        end
        check("pause_done", 1'b0, 1'b1);

        // Abort mid-transmission, then send a fresh word
        async_reset();
        for (int i = 0; i < 16; i++) begin
            tick(1'b1, W'($urandom));
            check_model($sformatf("pre_abort[%0d]", i));
        end
        async_reset();
        for (int i = 0; i < 34; i++) begin
            tick(1'b1, (i == 0) ? 32'hA5A5_A5A5 : W'($urandom));
            check_model($sformatf("retx[%0d]", i));
        end

        // Randomized traffic with occasional resets
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) < 2) begin
                async_reset();
            end else begin
                tick(logic'($urandom_range(0, 3) != 0), W'($urandom));
                check_model("random");
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
